// File: rtl/rast_iter_pkg.sv
// Shared sizing constants, FSM state type and sub-sample step lookup for the
// multi-sample iterator.
package rast_iter_pkg;

    localparam int SIGFIG = 24;
    localparam int RADIX  = 10;
    localparam int VERTS  = 3;
    localparam int AXIS   = 3;
    localparam int COLORS = 3;
    localparam int SAMPS  = 4;

    typedef enum logic {IDLE, ITER} iter_state_e;

    typedef logic signed [SIGFIG-1:0] pos_t;

    localparam logic [3:0] SS_1X  = 4'b1000;
    localparam logic [3:0] SS_4X  = 4'b0100;
    localparam logic [3:0] SS_16X = 4'b0010;
    localparam logic [3:0] SS_64X = 4'b0001;

    // Grid pitch in fixed point; an illegal code falls back to one sample per pixel.
    function automatic pos_t step_size(input logic [3:0] sub_sample);
        pos_t step;
        case (sub_sample)
            SS_4X:   step = pos_t'(1 << (RADIX - 1));
            SS_16X:  step = pos_t'(1 << (RADIX - 2));
            SS_64X:  step = pos_t'(1 << (RADIX - 3));
            default: step = pos_t'(1 << RADIX);
        endcase
        return step;
    endfunction

endpackage

// File: rtl/samp_iter_ctrl_if.sv
// Bundle between the bbox stage, the iterator and the sample-test stage.
interface samp_iter_ctrl_if;
    import rast_iter_pkg::*;

    logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R13S;
    logic        [COLORS-1:0][SIGFIG-1:0]          color_R13U;
    logic signed [1:0][1:0][SIGFIG-1:0]            box_R13S;
    logic                                          validTri_R13H;
    logic        [3:0]                             subSample_RnnnnU;

    logic                                          halt_RnnnnL;
    logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R14S;
    logic        [COLORS-1:0][SIGFIG-1:0]          color_R14U;
    logic signed [SAMPS-1:0][1:0][SIGFIG-1:0]      sample_R14S;
    logic        [SAMPS-1:0]                       validSamp_R14H;

    modport master (
        output tri_R13S, color_R13U, box_R13S, validTri_R13H, subSample_RnnnnU,
        input  halt_RnnnnL, tri_R14S, color_R14U, sample_R14S, validSamp_R14H
    );

    modport slave (
        input  tri_R13S, color_R13U, box_R13S, validTri_R13H, subSample_RnnnnU,
        output halt_RnnnnL, tri_R14S, color_R14U, sample_R14S, validSamp_R14H
    );

endinterface

// File: rtl/samp_iter_ctrl_step_gen.sv
// Combinational lane generator and raster advance for one iterator cycle.
module samp_step_gen import rast_iter_pkg::*; (
    input  pos_t cur_x,
    input  pos_t cur_y,
    input  pos_t ll_x,
    input  pos_t ur_x,
    input  pos_t ur_y,
    input  pos_t step,
    output pos_t nxt_x,
    output pos_t nxt_y,
    output logic row_wrap,
    output logic last,
    output logic signed [SAMPS-1:0][1:0][SIGFIG-1:0] lane_pos,
    output logic [SAMPS-1:0] lane_valid
);

    // One extra bit so sums near the top of the positive range never wrap negative.
    typedef logic signed [SIGFIG:0] wide_t;

    wide_t lane_x;
    wide_t nx;
    wide_t ny;
    logic  x_fits;
    logic  y_fits;

    always_comb begin
        lane_x     = wide_t'(cur_x);
        lane_pos   = '0;
        lane_valid = '0;
        for (int i = 0; i < SAMPS; i++) begin
            lane_pos[i][0] = lane_x[SIGFIG-1:0];
            lane_pos[i][1] = cur_y;
            lane_valid[i]  = (lane_x <= wide_t'(ur_x));
            lane_x         = lane_x + wide_t'(step);
        end
    end

    always_comb begin
        nx       = wide_t'(cur_x) + wide_t'(SAMPS) * wide_t'(step);
        ny       = wide_t'(cur_y) + wide_t'(step);
        x_fits   = (nx <= wide_t'(ur_x));
        y_fits   = (ny <= wide_t'(ur_y));
        row_wrap = !x_fits && y_fits;
        last     = !x_fits && !y_fits;
        nxt_x    = x_fits ? pos_t'(nx[SIGFIG-1:0]) : ll_x;
        nxt_y    = row_wrap ? pos_t'(ny[SIGFIG-1:0]) : cur_y;
    end

endmodule

// File: rtl/samp_iter_ctrl.sv
// Multi-sample iterator: accepts one bounded triangle, then walks its box in
// raster order issuing SAMPS adjacent sample locations per cycle.
module samp_iter_ctrl import rast_iter_pkg::*; (
    input  logic             clk,
    input  logic             rst,
    samp_iter_ctrl_if.slave  bus
);

    typedef logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_t;
    typedef logic [COLORS-1:0][SIGFIG-1:0]                 color_t;

    iter_state_e state_q, state_d;
    tri_t        tri_q, tri_d;
    color_t      color_q, color_d;
    pos_t        ll_x_q, ll_x_d;
    pos_t        ur_x_q, ur_x_d;
    pos_t        ur_y_q, ur_y_d;
    pos_t        step_q, step_d;
    pos_t        cur_x_q, cur_x_d;
    pos_t        cur_y_q, cur_y_d;

    pos_t        nxt_x;
    pos_t        nxt_y;
    logic        row_wrap;
    logic        last;
    logic signed [SAMPS-1:0][1:0][SIGFIG-1:0] lane_pos;
    logic        [SAMPS-1:0]                  lane_valid;

    samp_step_gen u_step_gen (
        .cur_x      (cur_x_q),
        .cur_y      (cur_y_q),
        .ll_x       (ll_x_q),
        .ur_x       (ur_x_q),
        .ur_y       (ur_y_q),
        .step       (step_q),
        .nxt_x      (nxt_x),
        .nxt_y      (nxt_y),
        .row_wrap   (row_wrap),
        .last       (last),
        .lane_pos   (lane_pos),
        .lane_valid (lane_valid)
    );

    always_comb begin
        state_d = state_q;
        tri_d   = tri_q;
        color_d = color_q;
        ll_x_d  = ll_x_q;
        ur_x_d  = ur_x_q;
        ur_y_d  = ur_y_q;
        step_d  = step_q;
        cur_x_d = cur_x_q;
        cur_y_d = cur_y_q;
        case (state_q)
            IDLE: begin
                if (bus.validTri_R13H) begin
                    tri_d   = bus.tri_R13S;
                    color_d = bus.color_R13U;
                    ll_x_d  = bus.box_R13S[0][0];
                    ur_x_d  = bus.box_R13S[1][0];
                    ur_y_d  = bus.box_R13S[1][1];
                    step_d  = step_size(bus.subSample_RnnnnU);
                    cur_x_d = bus.box_R13S[0][0];
                    cur_y_d = bus.box_R13S[0][1];
                    state_d = ITER;
                end
            end
            ITER: begin
                if (last) begin
                    state_d = IDLE;
                end else if (row_wrap) begin
                    cur_x_d = nxt_x;
                    cur_y_d = nxt_y;
                end else begin
                    cur_x_d = nxt_x;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            tri_q   <= '0;
            color_q <= '0;
            ll_x_q  <= '0;
            ur_x_q  <= '0;
            ur_y_q  <= '0;
            step_q  <= '0;
            cur_x_q <= '0;
            cur_y_q <= '0;
        end else begin
            state_q <= state_d;
            tri_q   <= tri_d;
            color_q <= color_d;
            ll_x_q  <= ll_x_d;
            ur_x_q  <= ur_x_d;
            ur_y_q  <= ur_y_d;
            step_q  <= step_d;
            cur_x_q <= cur_x_d;
            cur_y_q <= cur_y_d;
        end
    end

    // With step cleared by reset every lane sits at the origin until the first triangle.
    assign bus.halt_RnnnnL    = (state_q == IDLE);
    assign bus.tri_R14S       = tri_q;
    assign bus.color_R14U     = color_q;
    assign bus.sample_R14S    = lane_pos;
    assign bus.validSamp_R14H = (state_q == ITER) ? lane_valid : '0;

    a_stable_while_halted: assert property (@(posedge clk) disable iff (rst)
        (bus.validTri_R13H && !bus.halt_RnnnnL && $past(bus.validTri_R13H && !bus.halt_RnnnnL))
        |-> ($stable(bus.tri_R13S) && $stable(bus.color_R13U) &&
             $stable(bus.box_R13S) && $stable(bus.subSample_RnnnnU)));

    a_box_ordered: assert property (@(posedge clk) disable iff (rst)
        (state_q == IDLE && bus.validTri_R13H)
        |-> ($signed(bus.box_R13S[1][0]) >= $signed(bus.box_R13S[0][0]) &&
             $signed(bus.box_R13S[1][1]) >= $signed(bus.box_R13S[0][1])));

endmodule

// File: tb/tb_samp_iter_ctrl.sv
// Bench for samp_iter_ctrl: directed scenarios with literal expectations plus
// randomized triangles checked every cycle against a raster-walk model.
module tb_samp_iter_ctrl;
    import rast_iter_pkg::*;

    typedef logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_t;
    typedef logic [COLORS-1:0][SIGFIG-1:0]                 color_t;
    typedef logic signed [1:0][1:0][SIGFIG-1:0]            box_t;
    typedef struct {
        longint x;
        longint y;
        longint ur_x;
        longint step;
    } issue_t;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    int     tests = 0;
    int     fails = 0;
    bit     chk_en = 1'b0;
    issue_t exp_q[$];
    tri_t   m_tri;
    color_t m_color;

    samp_iter_ctrl_if bus();

    samp_iter_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    function automatic longint step_of(input logic [3:0] ss);
        case (ss)
            4'b0100: return 512;
            4'b0010: return 256;
            4'b0001: return 128;
            default: return 1024;
        endcase
    endfunction

    function automatic tri_t mk_tri(input int seed);
        tri_t t;
        for (int v = 0; v < VERTS; v++)
            for (int a = 0; a < AXIS; a++)
                t[v][a] = SIGFIG'(seed * 16 + v * 4 + a);
        return t;
    endfunction

    function automatic color_t mk_color(input int seed);
        color_t c;
        for (int k = 0; k < COLORS; k++)
            c[k] = SIGFIG'(seed * 8 + k + 1000);
        return c;
    endfunction

    function automatic box_t mk_box(input longint llx, input longint lly, input longint urx, input longint ury);
        box_t b;
        b[0][0] = SIGFIG'(llx);
        b[0][1] = SIGFIG'(lly);
        b[1][0] = SIGFIG'(urx);
        b[1][1] = SIGFIG'(ury);
        return b;
    endfunction

    // Model: a triangle expands into one queue entry per issue cycle, popped once per clock.
    always @(posedge clk) begin
        if (rst) begin
            exp_q.delete();
            m_tri   = '0;
            m_color = '0;
        end else if (exp_q.size() != 0) begin
            void'(exp_q.pop_front());
        end else if (bus.validTri_R13H) begin
            longint st, llx, lly, urx, ury;
            issue_t it;
            st      = step_of(bus.subSample_RnnnnU);
            llx     = longint'($signed(bus.box_R13S[0][0]));
            lly     = longint'($signed(bus.box_R13S[0][1]));
            urx     = longint'($signed(bus.box_R13S[1][0]));
            ury     = longint'($signed(bus.box_R13S[1][1]));
            m_tri   = bus.tri_R13S;
            m_color = bus.color_R13U;
            for (longint y = lly; y <= ury; y += st) begin
                for (longint x = llx; x <= urx; x += SAMPS * st) begin
                    it.x    = x;
                    it.y    = y;
                    it.ur_x = urx;
                    it.step = st;
                    exp_q.push_back(it);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            if (exp_q.size() == 0) begin
                checkOutput("halt_idle", 256'(bus.halt_RnnnnL), 256'(1));
                checkOutput("valid_idle", 256'(bus.validSamp_R14H), 256'(0));
            end else begin
                issue_t e;
                logic [SAMPS-1:0] ev;
                longint lx;
                e = exp_q[0];
                for (int i = 0; i < SAMPS; i++)
                    ev[i] = ((e.x + longint'(i) * e.step) <= e.ur_x);
                checkOutput("halt_iter", 256'(bus.halt_RnnnnL), 256'(0));
                checkOutput("validSamp", 256'(bus.validSamp_R14H), 256'(ev));
                for (int i = 0; i < SAMPS; i++) begin
                    lx = e.x + longint'(i) * e.step;
                    checkOutput($sformatf("lane%0d_x", i), 256'(bus.sample_R14S[i][0]), 256'(lx[SIGFIG-1:0]));
                    checkOutput($sformatf("lane%0d_y", i), 256'(bus.sample_R14S[i][1]), 256'(e.y[SIGFIG-1:0]));
                end
            end
            checkOutput("tri_out", 256'(bus.tri_R14S), 256'(m_tri));
            checkOutput("color_out", 256'(bus.color_R14U), 256'(m_color));
        end
    end

    // Presents a triangle once the iterator is ready; returns just after the accepting edge.
    task automatic applyStimulus(input tri_t t, input color_t c, input box_t b, input logic [3:0] ss, input bit hold);
        int guard;
        guard = 0;
        @(negedge clk);
        while (bus.halt_RnnnnL !== 1'b1 && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 300) begin
            tests++;
            fails++;
            $display("[TB] FAIL accept_wait: halt_RnnnnL stayed %b, required 1", bus.halt_RnnnnL);
            return;
        end
        bus.tri_R13S         = t;
        bus.color_R13U       = c;
        bus.box_R13S         = b;
        bus.subSample_RnnnnU = ss;
        bus.validTri_R13H    = 1'b1;
        @(posedge clk);
        #2;
        if (!hold)
            bus.validTri_R13H = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: time limit reached before completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        longint llx64;
        bus.tri_R13S         = '0;
        bus.color_R13U       = '0;
        bus.box_R13S         = '0;
        bus.validTri_R13H    = 1'b0;
        bus.subSample_RnnnnU = 4'b1000;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        rst    = 1'b0;
        chk_en = 1'b1;

        @(negedge clk);
        checkOutput("reset_halt", 256'(bus.halt_RnnnnL), 256'(1));
        checkOutput("reset_valid", 256'(bus.validSamp_R14H), 256'(0));
        checkOutput("reset_sample", 256'(bus.sample_R14S), 256'(0));
        checkOutput("reset_tri", 256'(bus.tri_R14S), 256'(0));
        checkOutput("reset_color", 256'(bus.color_R14U), 256'(0));

        $display("[TB] 1x 4x2 box");
        applyStimulus(mk_tri(1), mk_color(1), mk_box(0, 0, 3072, 1024), 4'b1000, 1'b0);
        @(negedge clk);
        checkOutput("t1_c1_valid", 256'(bus.validSamp_R14H), 256'(4'b1111));
        checkOutput("t1_c1_lane3_x", 256'(bus.sample_R14S[3][0]), 256'(3072));
        checkOutput("t1_c1_y", 256'(bus.sample_R14S[0][1]), 256'(0));
        checkOutput("t1_c1_halt", 256'(bus.halt_RnnnnL), 256'(0));
        @(negedge clk);
        checkOutput("t1_c2_valid", 256'(bus.validSamp_R14H), 256'(4'b1111));
        checkOutput("t1_c2_lane2_x", 256'(bus.sample_R14S[2][0]), 256'(2048));
        checkOutput("t1_c2_y", 256'(bus.sample_R14S[1][1]), 256'(1024));
        checkOutput("t1_c2_halt", 256'(bus.halt_RnnnnL), 256'(0));
        @(negedge clk);
        checkOutput("t1_c3_halt", 256'(bus.halt_RnnnnL), 256'(1));

        $display("[TB] 4x partial row");
        applyStimulus(mk_tri(2), mk_color(2), mk_box(0, 0, 1024, 0), 4'b0100, 1'b0);
        @(negedge clk);
        checkOutput("t2_valid", 256'(bus.validSamp_R14H), 256'(4'b0111));
        checkOutput("t2_lane3_x", 256'(bus.sample_R14S[3][0]), 256'(1536));
        @(negedge clk);
        checkOutput("t2_halt_after", 256'(bus.halt_RnnnnL), 256'(1));

        $display("[TB] degenerate box");
        applyStimulus(mk_tri(3), mk_color(3), mk_box(2048, 5120, 2048, 5120), 4'b1000, 1'b0);
        @(negedge clk);
        checkOutput("t3_valid", 256'(bus.validSamp_R14H), 256'(4'b0001));
        checkOutput("t3_lane0_x", 256'(bus.sample_R14S[0][0]), 256'(2048));
        checkOutput("t3_lane0_y", 256'(bus.sample_R14S[0][1]), 256'(5120));
        @(negedge clk);
        checkOutput("t3_halt_after", 256'(bus.halt_RnnnnL), 256'(1));

        $display("[TB] back-to-back triangles");
        applyStimulus(mk_tri(7), mk_color(7), mk_box(0, 0, 1024, 1024), 4'b1000, 1'b1);
        applyStimulus(mk_tri(9), mk_color(9), mk_box(1024, 0, 2048, 0), 4'b1000, 1'b0);
        @(negedge clk);
        checkOutput("t4_tri", 256'(bus.tri_R14S), 256'(mk_tri(9)));
        checkOutput("t4_color", 256'(bus.color_R14U), 256'(mk_color(9)));
        checkOutput("t4_valid", 256'(bus.validSamp_R14H), 256'(4'b0011));
        checkOutput("t4_lane0_x", 256'(bus.sample_R14S[0][0]), 256'(1024));

        $display("[TB] reset during row 2");
        applyStimulus(mk_tri(5), mk_color(5), mk_box(0, 0, 1024, 2048), 4'b1000, 1'b0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("t5_rst_valid", 256'(bus.validSamp_R14H), 256'(0));
        checkOutput("t5_rst_halt", 256'(bus.halt_RnnnnL), 256'(1));
        applyStimulus(mk_tri(6), mk_color(6), mk_box(5120, 3072, 6144, 3072), 4'b1000, 1'b0);
        @(negedge clk);
        checkOutput("t5_new_x", 256'(bus.sample_R14S[0][0]), 256'(5120));
        checkOutput("t5_new_y", 256'(bus.sample_R14S[0][1]), 256'(3072));
        checkOutput("t5_new_valid", 256'(bus.validSamp_R14H), 256'(4'b0011));

        $display("[TB] 64x near positive limit");
        llx64 = 64'd8387840;
        applyStimulus(mk_tri(8), mk_color(8), mk_box(llx64, 0, 8388480, 128), 4'b0001, 1'b0);
        @(negedge clk);
        checkOutput("t6_c1_valid", 256'(bus.validSamp_R14H), 256'(4'b1111));
        checkOutput("t6_c1_lane0_x", 256'(bus.sample_R14S[0][0]), 256'(8387840));
        @(negedge clk);
        checkOutput("t6_c2_valid", 256'(bus.validSamp_R14H), 256'(4'b0011));
        checkOutput("t6_c2_lane1_x", 256'(bus.sample_R14S[1][0]), 256'(8388480));
        @(negedge clk);
        checkOutput("t6_c3_lane0_x", 256'(bus.sample_R14S[0][0]), 256'(8387840));
        checkOutput("t6_c3_y", 256'(bus.sample_R14S[0][1]), 256'(128));
        checkOutput("t6_c3_halt", 256'(bus.halt_RnnnnL), 256'(0));
        @(negedge clk);
        @(negedge clk);
        checkOutput("t6_halt_after", 256'(bus.halt_RnnnnL), 256'(1));

        $display("[TB] randomized triangles");
        for (int n = 0; n < 60; n++) begin
            logic [3:0] ss;
            longint     st, llx, lly;
            int         w, h;
            bit         hold;
            ss   = 4'b1000 >> $urandom_range(0, 3);
            st   = step_of(ss);
            w    = $urandom_range(1, 11);
            h    = $urandom_range(1, 4);
            llx  = (longint'($urandom_range(0, 200)) - 100) * st;
            lly  = (longint'($urandom_range(0, 200)) - 100) * st;
            hold = ($urandom_range(0, 3) == 0);
            applyStimulus(mk_tri(n + 20), mk_color(n + 20),
                          mk_box(llx, lly, llx + longint'(w - 1) * st, lly + longint'(h - 1) * st),
                          ss, hold);
            if (!hold) begin
                bus.subSample_RnnnnU = 4'b1000 >> $urandom_range(0, 3);
                repeat ($urandom_range(0, 3)) @(posedge clk);
            end
        end
        bus.validTri_R13H = 1'b0;
        repeat (80) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/samp_iter_ctrl.md
Name: samp_iter_ctrl

Overview:
- Multi-sample iterator and controller that sequences the sample-test datapath.
- Accepts one triangle at a time, with its bounding box, from the bbox stage.
- Walks the box on the sub-sample grid in raster order, issuing SAMPS horizontally adjacent sample locations per cycle, each with a per-lane valid, to the sample-test stage.
- Stalls upstream with an active-low halt while a triangle is being walked.

Parameters:
SIGFIG, 24, bits in position and color words
RADIX, 10, fraction bits; 1.0 = 1<<RADIX
VERTS, 3, vertices per triangle
AXIS, 3, axes per vertex (x,y,z)
COLORS, 3, color channels
SAMPS, 4, sample lanes issued per cycle; power of two, 1..8

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
tri_R13S  in  signed SIGFIG x VERTS x AXIS  triangle
color_R13U  in  SIGFIG x COLORS  triangle color
box_R13S  in  signed SIGFIG x 2 x 2  [0]=LL,[1]=UR; [.][0]=x,[.][1]=y; grid-snapped
validTri_R13H  in  1  triangle/box valid
subSample_RnnnnU  in  4  one-hot MSAA: 1000=1x, 0100=4x, 0010=16x, 0001=64x
halt_RnnnnL  out  1  1 = ready for a new triangle; 0 = stall upstream
tri_R14S  out  signed SIGFIG x VERTS x AXIS  latched triangle
color_R14U  out  SIGFIG x COLORS  latched color
sample_R14S  out  signed SIGFIG x 2 x SAMPS  [0]=x,[1]=y per lane
validSamp_R14H  out  SAMPS  per-lane sample valid

Behaviour:
- Reset values:
  - State IDLE.
  - halt_RnnnnL=1.
  - validSamp_R14H all 0.
  - sample_R14S, tri_R14S and color_R14U all 0.
- Step size from subSample, captured at acceptance:
  - 1x: step = 1<<RADIX
  - 4x: step = 1<<(RADIX-1)
  - 16x: step = 1<<(RADIX-2)
  - 64x: step = 1<<(RADIX-3)
- Lane geometry: lane i x = cur_x + i*step; all lanes share y = cur_y.
- FSM state IDLE:
  - halt_RnnnnL=1; validSamp all 0.
  - If validTri_R13H=1 at a clock edge: latch tri, color, box and step; cur = LL; go to ITER.
- FSM state ITER:
  - halt_RnnnnL=0, combinationally from state.
  - Each cycle outputs lanes at (cur_x + i*step, cur_y).
  - validSamp[i] = (cur_x + i*step <= UR_x).
- Advance rule in ITER, using SIGFIG+1-bit intermediates with no wrap:
  - nx = cur_x + SAMPS*step.
  - If nx <= UR_x: cur_x = nx.
  - Else if cur_y + step <= UR_y: cur_x = LL_x, cur_y += step.
  - Else: last cycle; go to IDLE.
- Latency and throughput:
  - A triangle accepted at edge t produces its first samples during cycle t+1.
  - A box of W x H grid points takes H*ceil(W/SAMPS) cycles.
  - halt_RnnnnL returns to 1 in the cycle after the last issue cycle.
  - There is no back-to-back acceptance; at least 1 IDLE cycle separates triangles.
- Degenerate box (LL == UR): exactly 1 ITER cycle with only lane 0 valid.
- validTri_R13H while in ITER is ignored; upstream must honour halt. An assertion fires if validTri=1 while halt_RnnnnL=0 and the input changes.
- Contract assertion: UR >= LL on both axes at acceptance.
- subSample changes mid-triangle have no effect until the next acceptance.
- Reset mid-ITER: the next cycle is IDLE with all validSamp 0 and halt=1; the partial triangle is discarded.
- tri_R14S and color_R14U hold their latched value through IDLE; they are only updated on acceptance.

Decomposition:
- Package rast_iter_pkg:
  - typedef iter_state_e {IDLE, ITER}
  - typedef pos_t (signed SIGFIG)
  - constants for subSample one-hot codes
  - step-size function
- Sub-module samp_step_gen (combinational):
  - Inputs: cur, box, step.
  - Outputs: next position, row-wrap flag, last flag, lane positions and lane valids.
  - The FSM and the latch registers stay in samp_iter_ctrl.

Test Plan:
- 1x, SAMPS=4, box LL=(0,0) UR=(3072,1024):
  - Cycle 1: lane x = 0,1024,2048,3072 at y=0, validSamp=1111.
  - Cycle 2: same x at y=1024, validSamp=1111.
  - IDLE follows; halt low exactly 2 cycles.
- 4x, box LL=(0,0) UR=(1024,0), step=512:
  - Cycle 1: x = 0,512,1024,1536, validSamp=0111 with lane 0 in the LSB, i.e. lanes 0-2 valid and lane 3 (x=1536) invalid.
  - Returns to IDLE after 1 cycle.
- Degenerate box LL=UR=(2048,5120) at 1x: 1 cycle, validSamp=0001, sample[0]=(2048,5120).
- Assert validTri for 2 triangles back-to-back while halt honoured:
  - The second triangle is accepted only after halt returns to 1.
  - The second triangle's samples carry its own tri/color.
- Assert rst for 1 cycle during row 2 of a 3-row box:
  - The next cycle has validSamp=0000 and halt=1.
  - A new triangle presented afterwards iterates from its own LL.
- 64x, box UR_x = (1<<(SIGFIG-1)) - 128 (near max positive):
  - The row advance does not wrap negative.
  - The row terminates correctly, with lanes beyond UR invalid.
